// File: rtl/inst_fetch_queue.sv
// In-order instruction fetch queue: issues credit-limited sequential fetches to the I-cache,
// buffers returned words with their PC and fault tag, and flushes/drops stale data on redirect.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_OUT  = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_pc,
  input  logic        resp_valid,
  input  logic [31:0] resp_inst,
  input  logic        resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(MAX_OUT) + 1;

  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];
  logic          r_mem_err  [DEPTH];

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_pend;
  logic [PW-1:0] r_drop;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_lock;
  logic          r_mis;

  logic [31:0]   w_used;
  logic          w_req_fire;
  logic          w_pop;
  logic          w_resp_wr;
  logic          w_wr;
  logic [31:0]   w_wr_inst;
  logic          w_wr_err;

  // Slots already claimed: buffered entries plus live (non-stale) outstanding requests.
  assign w_used     = 32'(r_count) + 32'(r_pend) - 32'(r_drop);
  assign req_valid  = rst & ~redirect & ~r_lock & (r_fetch_pc[1:0] == 2'b00) &
                      (32'(r_pend) < MAX_OUT) & (w_used < DEPTH);
  assign req_pc     = r_fetch_pc;
  assign w_req_fire = req_valid & req_ready;

  assign inst_valid = (r_count != '0);
  assign w_pop      = inst_valid & inst_ready;

  // A misaligned redirect target owns the write port for exactly one cycle.
  assign w_resp_wr  = resp_valid & (r_drop == '0) & ~r_lock & ~r_mis;
  assign w_wr       = w_resp_wr | r_mis;
  assign w_wr_inst  = r_mis ? 32'd0 : resp_inst;
  assign w_wr_err   = r_mis | resp_err;

  assign inst       = inst_valid ? r_mem_inst[r_rd_ptr] : 32'd0;
  assign inst_pc    = inst_valid ? r_mem_pc[r_rd_ptr]   : 32'd0;
  assign inst_err   = inst_valid ? r_mem_err[r_rd_ptr]  : 1'b0;

  always_ff @(posedge clk) begin
    if (!redirect && w_wr) begin
      r_mem_inst[r_wr_ptr] <= w_wr_inst;
      r_mem_pc[r_wr_ptr]   <= r_resp_pc;
      r_mem_err[r_wr_ptr]  <= w_wr_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_pend     <= '0;
      r_drop     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_lock     <= 1'b0;
      r_mis      <= 1'b0;
    end else if (redirect) begin
      // Everything still in flight is stale; pend keeps counting it down as it returns.
      r_fetch_pc <= redirect_pc;
      r_resp_pc  <= redirect_pc;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_lock     <= 1'b0;
      r_pend     <= r_pend - PW'(resp_valid);
      r_drop     <= r_pend - PW'(resp_valid);
      r_mis      <= (redirect_pc[1:0] != 2'b00);
    end else begin
      if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_resp_wr)  r_resp_pc  <= r_resp_pc + 32'd4;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      r_pend  <= r_pend + PW'(w_req_fire) - PW'(resp_valid);
      if (resp_valid && (r_drop != '0)) r_drop <= r_drop - PW'(1);
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (r_mis || (w_resp_wr && resp_err)) r_lock <= 1'b1;
      r_mis <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (!rst)
    !(!redirect && w_wr && (32'(r_count) == DEPTH) && !w_pop));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with redirects and faults.
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;
  localparam int MAX_OUT = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  logic clk;
  logic rst;
  logic req_valid, req_ready, resp_valid, resp_err, inst_valid, inst_ready, inst_err, redirect;
  logic [31:0] req_pc, resp_inst, inst, inst_pc, redirect_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_inst(resp_inst), .resp_err(resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_err(inst_err), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } ent_t;

  int n_tests = 0;
  int n_fail  = 0;

  ent_t        mq[$];    // entries the decoder should see, oldest first
  logic [31:0] ic_q[$];  // PCs of requests the I-cache still owes a response for
  logic [31:0] m_fetch, m_resp;
  int          m_drop;
  bit          m_lock, m_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (pc * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event never observed within cycle budget", name);
  endtask

  task automatic m_reset();
    mq.delete();
    ic_q.delete();
    m_fetch = RESET_PC;
    m_resp  = RESET_PC;
    m_drop  = 0;
    m_lock  = 0;
    m_mis   = 0;
  endtask

  // Compare settled outputs with the model, then advance the model by one clock.
  task automatic step();
    bit   e_rv;
    ent_t e;
    e_rv = !redirect && !m_lock && (m_fetch[1:0] == 2'b00) && (ic_q.size() < MAX_OUT) &&
           ((mq.size() + ic_q.size() - m_drop) < DEPTH);
    chk("req_valid", req_valid, e_rv);
    if (e_rv) chk("req_pc", req_pc, m_fetch);
    chk("inst_valid", inst_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("inst", inst, mq[0].inst);
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst_err", inst_err, mq[0].err);
    end
    if (redirect) begin
      if (resp_valid) void'(ic_q.pop_front());
      m_drop  = ic_q.size();
      mq.delete();
      m_lock  = 0;
      m_mis   = (redirect_pc[1:0] != 2'b00);
      m_fetch = redirect_pc;
      m_resp  = redirect_pc;
    end else begin
      if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
      if (m_mis) begin
        e.inst = 32'd0; e.pc = m_resp; e.err = 1'b1;
        mq.push_back(e);
        m_lock = 1;
        m_mis  = 0;
      end
      if (resp_valid) begin
        void'(ic_q.pop_front());
        if (m_drop > 0) m_drop--;
        else if (!m_lock) begin
          e.inst = resp_inst; e.pc = m_resp; e.err = resp_err;
          mq.push_back(e);
          m_resp += 32'd4;
          if (resp_err) m_lock = 1;
        end
      end
      if (e_rv && req_ready) begin
        ic_q.push_back(m_fetch);
        m_fetch += 32'd4;
      end
    end
  endtask

  task automatic adv();
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic auto_resp(input logic [31:0] err_pc);
    if (ic_q.size() != 0) begin
      resp_valid = 1'b1;
      resp_inst  = mem_word(ic_q[0]);
      resp_err   = (ic_q[0] == err_pc);
    end else begin
      resp_valid = 1'b0;
      resp_inst  = 32'd0;
      resp_err   = 1'b0;
    end
  endtask

  initial begin
    int fires, seen, dlv;
    bit ok;
    logic err2;
    logic [31:0] rp;
    rst = 1'b0; req_ready = 0; resp_valid = 0; resp_err = 0; resp_inst = '0;
    inst_ready = 0; redirect = 0; redirect_pc = '0;
    m_reset();
    #2;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_err", inst_err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Sequential fetch with one-cycle response latency.
    req_ready = 1; inst_ready = 1;
    for (int i = 0; i < 4; i++) begin
      auto_resp(32'h1); #1;
      chk("s1_req_pc", req_pc, RESET_PC + 32'(4 * i));
      if (i >= 2) chk("s1_inst_pc", inst_pc, RESET_PC + 32'(4 * (i - 2)));
      adv();
    end

    // Fill with decoder stalled, then free one slot, then drain.
    redirect = 1; redirect_pc = 32'h0000_1000; auto_resp(32'h1); #1; adv(); redirect = 0;
    inst_ready = 0; fires = 0;
    for (int i = 0; i < 20; i++) begin
      auto_resp(32'h1); #1;
      if (req_valid && req_ready) fires++;
      adv();
    end
    chk("s2_fill_reqs", fires, 8);
    fires = 0; inst_ready = 1; auto_resp(32'h1); #1;
    if (req_valid && req_ready) fires++;
    adv();
    inst_ready = 0;
    for (int i = 0; i < 10; i++) begin
      auto_resp(32'h1); #1;
      if (req_valid && req_ready) fires++;
      adv();
    end
    chk("s2_refill_reqs", fires, 1);
    req_ready = 0; inst_ready = 1; dlv = 0;
    for (int i = 0; i < 12; i++) begin
      auto_resp(32'h1); #1;
      if (inst_valid) dlv++;
      adv();
    end
    chk("s2_drain", dlv, 8);

    // Redirect with three requests outstanding.
    resp_valid = 0; redirect = 1; redirect_pc = 32'h2000; #1; adv(); redirect = 0;
    req_ready = 1; inst_ready = 1;
    for (int i = 0; i < 3; i++) begin resp_valid = 0; #1; adv(); end
    chk("s3_pend", ic_q.size(), 3);
    redirect = 1; redirect_pc = 32'h8000_1000; resp_valid = 0; #1;
    chk("s3_iv_redir", inst_valid, 0);
    adv(); redirect = 0;
    auto_resp(32'h1); #1;
    chk("s3_iv_after", inst_valid, 0);
    adv();
    ok = 0;
    for (int i = 0; i < 15 && !ok; i++) begin
      auto_resp(32'h1); #1;
      if (inst_valid) begin
        ok = 1;
        chk("s3_first_pc", inst_pc, 32'h8000_1000);
        chk("s3_first_inst", inst, mem_word(32'h8000_1000));
      end
      adv();
    end
    if (!ok) fail_to("s3_first_entry");

    // Misaligned redirect target.
    inst_ready = 0; redirect = 1; redirect_pc = 32'h8000_1002; auto_resp(32'h1); #1; adv(); redirect = 0;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      auto_resp(32'h1); #1;
      chk("s4_no_req", req_valid, 0);
      if (inst_valid && !ok) begin
        ok = 1;
        chk("s4_inst", inst, 32'd0);
        chk("s4_inst_pc", inst_pc, 32'h8000_1002);
        chk("s4_inst_err", inst_err, 1);
      end
      adv();
    end
    if (!ok) fail_to("s4_entry");
    seen = 0; inst_ready = 1;
    for (int i = 0; i < 8; i++) begin
      auto_resp(32'h1); #1;
      if (inst_valid) seen++;
      adv();
    end
    chk("s4_single_entry", seen, 1);

    // Fault on the second response locks fetch until a redirect.
    redirect = 1; redirect_pc = 32'h3000; auto_resp(32'h1); #1; adv(); redirect = 0;
    dlv = 0; err2 = 0;
    for (int i = 0; i < 15; i++) begin
      auto_resp(32'h3004); #1;
      if (inst_valid && inst_ready) begin
        dlv++;
        if (dlv == 2) err2 = inst_err;
      end
      adv();
    end
    chk("s5_delivered", dlv, 2);
    chk("s5_err2", err2, 1);
    auto_resp(32'h1); #1;
    chk("s5_locked", req_valid, 0);
    adv();
    redirect = 1; redirect_pc = 32'h4000; auto_resp(32'h1); #1; adv(); redirect = 0;
    auto_resp(32'h1); #1;
    chk("s5_resume_valid", req_valid, 1);
    chk("s5_resume_pc", req_pc, 32'h4000);
    adv();

    // Asynchronous reset with pend=2 and count=5.
    redirect = 1; redirect_pc = 32'h5000; req_ready = 0; inst_ready = 0; resp_valid = 0; #1; adv();
    redirect = 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (mq.size() == 5 && ic_q.size() == 2) ok = 1;
      else begin
        req_ready = ((mq.size() + ic_q.size()) < 7);
        auto_resp(32'h1);
        resp_valid = resp_valid && (mq.size() < 5);
        #1; adv();
      end
    end
    chk("s6_pre_count", mq.size(), 5);
    chk("s6_pre_pend", ic_q.size(), 2);
    req_ready = 0; resp_valid = 0;
    #2; rst = 1'b0; #1;
    chk("s6_rst_req_valid", req_valid, 0);
    chk("s6_rst_inst_valid", inst_valid, 0);
    chk("s6_rst_inst", inst, 0);
    chk("s6_rst_inst_pc", inst_pc, 0);
    chk("s6_rst_inst_err", inst_err, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    req_ready = 1; auto_resp(32'h1); #1;
    chk("s6_restart_valid", req_valid, 1);
    chk("s6_restart_pc", req_pc, RESET_PC);
    adv();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      redirect = ($urandom_range(0, 39) == 0);
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) rp = 32'hFFFF_FFF8;
      redirect_pc = rp;
      req_ready  = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      auto_resp(32'h1);
      if (resp_valid) begin
        resp_valid = ($urandom_range(0, 2) != 0);
        resp_err   = ($urandom_range(0, 29) == 0);
      end
      #1; adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
